// File: rtl/pipeline_sequencer_if.sv
// Pipeline control bundle between the sequencer and the 5-stage datapath.
//   master (sequencer): reads InstrF and the decode/EX/MEM register indices,
//                       drives PCF and the IF/ID and ID/EX stall/flush/bubble controls.
//   slave  (datapath) : the mirror image.
interface pipeline_sequencer_if #(
  parameter int unsigned I    = 32,
  parameter int unsigned PC_W = 10
);

  // Fetch and hazard-detection inputs to the sequencer
  logic [I-1:0]    InstrF;
  logic [3:0]      RA1D;
  logic [3:0]      RA2D;
  logic            RegWriteE;
  logic [3:0]      WA3E;
  logic            RegWriteM;
  logic [3:0]      WA3M;

  // Fetch address and segment controls from the sequencer
  logic [PC_W-1:0] PCF;
  logic            StallF;
  logic            StallD;
  logic            FlushE;
  logic            BubbleF;

  modport master (
    input  InstrF, RA1D, RA2D, RegWriteE, WA3E, RegWriteM, WA3M,
    output PCF, StallF, StallD, FlushE, BubbleF
  );

  modport slave (
    output InstrF, RA1D, RA2D, RegWriteE, WA3E, RegWriteM, WA3M,
    input  PCF, StallF, StallD, FlushE, BubbleF
  );

endinterface

// File: rtl/pipeline_sequencer.sv
// Run/halt sequencer and RAW-hazard stall controller for the 5-stage vector pipeline.
// Owns the fetch PC; holds decode while a source register is still pending in EX or MEM
// (no forwarding). A start pulse launches from PC 0; HALT or the last PC drains the pipe,
// after which done is raised until the next start or reset.
// Ports:
//   clk, reset   - clock, synchronous active-high reset
//   start        - one-cycle launch pulse, honoured only in IDLE or DONE
//   pipe         - control bundle (master): InstrF/RA*/WA*/RegWrite* in, PCF/Stall*/FlushE/BubbleF out
//   busy, done   - RUN|DRAIN, DONE
//   cycle_count  - RUN+DRAIN cycles, saturating
//   stall_count  - hazard-stall cycles, saturating
module pipeline_sequencer #(
  parameter int unsigned I       = 32,
  parameter int unsigned PC_W    = 10,
  parameter logic [3:0]  HALT_OP = 4'hF,
  parameter int unsigned DRAIN   = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  pipeline_sequencer_if.master pipe,
  output logic                 busy,
  output logic                 done,
  output logic [31:0]          cycle_count,
  output logic [31:0]          stall_count
);

  // Drain counter must hold DRAIN-1
  localparam int unsigned DCW = (DRAIN > 1) ? $clog2(DRAIN) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [DCW-1:0]  drain_q, drain_d;
  logic [31:0]     cyc_q, cyc_d;
  logic [31:0]     stl_q, stl_d;

  logic active_c;
  logic raw_c;
  logic hazard_c;
  logic halt_c;
  logic last_pc_c;
  logic stall_c;
  logic bubble_c;
  logic unused_instr_bits;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Hazard and fetch decode
  assign active_c  = (state_q == S_RUN) || (state_q == S_DRAIN);
  // WB is not compared: the regfile writes before it is read in the same cycle
  assign raw_c     = (pipe.RegWriteE && ((pipe.WA3E == pipe.RA1D) || (pipe.WA3E == pipe.RA2D))) ||
                     (pipe.RegWriteM && ((pipe.WA3M == pipe.RA1D) || (pipe.WA3M == pipe.RA2D)));
  assign hazard_c  = active_c && raw_c;
  assign halt_c    = (pipe.InstrF[I-1 -: 4] == HALT_OP);
  assign last_pc_c = (pc_q == {PC_W{1'b1}});
  assign unused_instr_bits = ^pipe.InstrF[I-5:0];

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      drain_q <= '0;
      cyc_q   <= '0;
      stl_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      drain_q <= drain_d;
      cyc_q   <= cyc_d;
      stl_q   <= stl_d;
    end
  end

  // Next-state, PC, drain counter and statistics
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    drain_d = drain_q;
    cyc_d   = cyc_q;
    stl_d   = stl_q;

    if (active_c) begin
      cyc_d = sat_inc(cyc_q);
      if (hazard_c) begin
        stl_d = sat_inc(stl_q);
      end
    end

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_RUN;
          pc_d    = '0;
          drain_d = '0;
          cyc_d   = '0;
          stl_d   = '0;
        end
      end
      S_RUN: begin
        // A stall holds PC, so HALT / last PC is re-evaluated once decode clears
        if (!hazard_c) begin
          if (halt_c || last_pc_c) begin
            state_d = S_DRAIN;
            drain_d = DCW'(DRAIN - 1);
          end else begin
            pc_d = pc_q + PC_W'(1);
          end
        end
      end
      S_DRAIN: begin
        if (!hazard_c) begin
          if (drain_q == '0) begin
            state_d = S_DONE;
          end else begin
            drain_d = drain_q - DCW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Segment controls and status
  always_comb begin
    stall_c  = 1'b0;
    bubble_c = 1'b1;
    busy     = 1'b0;
    done     = 1'b0;

    unique case (state_q)
      S_RUN: begin
        busy = 1'b1;
        if (hazard_c) begin
          stall_c  = 1'b1;
          bubble_c = 1'b0;
        end else begin
          // HALT is never issued; the last-PC instruction is
          bubble_c = halt_c;
        end
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (hazard_c) begin
          stall_c  = 1'b1;
          bubble_c = 1'b0;
        end
      end
      S_DONE: begin
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  assign pipe.PCF     = pc_q;
  assign pipe.StallF  = stall_c;
  assign pipe.StallD  = stall_c;
  assign pipe.FlushE  = stall_c;
  assign pipe.BubbleF = bubble_c;
  assign cycle_count  = cyc_q;
  assign stall_count  = stl_q;

endmodule
